// File: rtl/pipe_pkg.sv
// Pipeline-wide constants and the WB control bundle shared by the
// ID/EX, EX/MEM and MEM/WB registers, the control unit and write-back.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Field order matches the raw 2-bit bundle: bit1 = RegWrite, bit0 = MemToReg.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: synchronous reset, one write port and
// two combinational read ports with write-first bypass.
module regfile_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int REG_N    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic              zero_hit_w;

  assign zero_hit_w = (ZERO_REG != 0) && (waddr == '0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_d[i] = '0;
    end else if (we && !zero_hit_w) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Register 0 wins over the bypass so a stray write to it is never visible.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0)) return '0;
    if (we && !zero_hit_w && (addr == waddr)) return wdata;
    return regs_q[addr];
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, qualifies the write,
// commits into the register file and counts retired writes.
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int REG_N    = 8,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [ADDR_W-1:0] treg_in,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  retired_cnt
);

  import pipe_pkg::*;

  wb_ctrl_t         wb_ctrl;
  logic [CNT_W-1:0] retired_cnt_q;
  logic [CNT_W-1:0] retired_cnt_d;

  assign wb_ctrl = wb_ctrl_t'(wb_in);
  assign wb_data = wb_ctrl.mem_to_reg ? read_data_in : alu_out_in;

  // Reset kills the write so the flushed instruction never retires.
  assign wb_we = wb_ctrl.reg_write && !rst &&
                 !((ZERO_REG != 0) && (treg_in == '0));

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (rst) begin
      retired_cnt_d = '0;
    end else if (wb_we) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_N   (REG_N),
    .ZERO_REG(ZERO_REG)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (treg_in),
    .wdata (wb_data),
    .raddr1(rs1_addr),
    .raddr2(rs2_addr),
    .rdata1(rs1_data),
    .rdata2(rs2_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed cases followed by random traffic, checked
// against an array-based model of the register file and retire counter.
module tb_wb_regfile;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  wb_in;
  logic [15:0] read_data_in;
  logic [15:0] alu_out_in;
  logic [2:0]  treg_in;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [15:0] rs1_data, rs2_data, wb_data;
  logic        wb_we;
  logic [15:0] retired_cnt;

  logic [15:0] rs1_data_w, rs2_data_w, wb_data_w;
  logic        wb_we_w;
  logic [3:0]  retired_cnt_w;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .read_data_in(read_data_in),
    .alu_out_in(alu_out_in), .treg_in(treg_in), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .retired_cnt(retired_cnt)
  );

  // Narrow-counter copy on the same inputs: exercises wrap-around quickly.
  wb_regfile #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .wb_in(wb_in), .read_data_in(read_data_in),
    .alu_out_in(alu_out_in), .treg_in(treg_in), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data_w), .rs2_data(rs2_data_w),
    .wb_data(wb_data_w), .wb_we(wb_we_w), .retired_cnt(retired_cnt_w)
  );

  // reference model + scoreboard
  logic [15:0] model_regs [8];
  int unsigned model_cnt;
  bit          model_known;
  logic [15:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a, input bit we,
                                             input logic [2:0] t, input logic [15:0] d);
    if (a == 3'd0) return 16'h0;
    if (we && a == t) return d;
    return model_regs[a];
  endfunction

  // driver: apply one cycle of inputs, check combinational outputs, clock, check counter
  task automatic step(input logic r, input logic [1:0] wb, input logic [15:0] rd,
                      input logic [15:0] alu, input logic [2:0] t,
                      input logic [2:0] a1, input logic [2:0] a2);
    logic [15:0] exp_wb;
    bit          exp_we;
    logic [15:0] e;
    rst = r; wb_in = wb; read_data_in = rd; alu_out_in = alu;
    treg_in = t; rs1_addr = a1; rs2_addr = a2;
    #2;
    exp_wb = wb[0] ? rd : alu;
    exp_we = wb[1] && !r && (t != 3'd0);
    check("wb_data", {16'h0, wb_data}, {16'h0, exp_wb});
    check("wb_we", {31'h0, wb_we}, {31'h0, exp_we});
    if (model_known) begin
      check("rs1_data", {16'h0, rs1_data}, {16'h0, model_read(a1, exp_we, t, exp_wb)});
      check("rs2_data", {16'h0, rs2_data}, {16'h0, model_read(a2, exp_we, t, exp_wb)});
      check("rs1_data_w", {16'h0, rs1_data_w}, {16'h0, model_read(a1, exp_we, t, exp_wb)});
    end
    if (r) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;
      model_cnt = 0;
    end else if (exp_we) begin
      model_regs[t] = exp_wb;
      model_cnt++;
    end
    exp_q.push_back(model_cnt[15:0]);
    @(posedge clk);
    #1;
    if (r) model_known = 1'b1;
    if (model_known) begin
      e = exp_q.pop_front();
      check("retired_cnt", {16'h0, retired_cnt}, {16'h0, e});
      check("retired_cnt_w4", {28'h0, retired_cnt_w}, {28'h0, e[3:0]});
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  logic [2:0] t_r, a1_r, a2_r;

  initial begin
    model_known = 1'b0;
    model_cnt   = 0;
    rst = 1'b1; wb_in = 2'b00; read_data_in = '0; alu_out_in = '0;
    treg_in = '0; rs1_addr = '0; rs2_addr = '0;

    // reset held two cycles with a write request present
    step(1'b1, 2'b10, 16'h0000, 16'h1234, 3'd3, 3'd3, 3'd3);
    step(1'b1, 2'b10, 16'h0000, 16'h1234, 3'd3, 3'd3, 3'd0);
    // ALU write with same-cycle bypass, then read back
    step(1'b0, 2'b10, 16'h0000, 16'hBEEF, 3'd5, 3'd5, 3'd5);
    step(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd3);
    // load write
    step(1'b0, 2'b11, 16'h00A5, 16'hFFFF, 3'd2, 3'd2, 3'd2);
    step(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd2);
    // write to register 0 is suppressed
    step(1'b0, 2'b10, 16'h0000, 16'h7777, 3'd0, 3'd0, 3'd0);
    // RegWrite low: no state change; prior value of reg4 visible
    step(1'b0, 2'b10, 16'h0000, 16'h4444, 3'd4, 3'd1, 3'd1);
    step(1'b0, 2'b01, 16'h5555, 16'h0000, 3'd4, 3'd4, 3'd4);
    step(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 3'd4, 3'd4);
    // reset has priority over a concurrent write
    step(1'b0, 2'b10, 16'h0000, 16'h1111, 3'd1, 3'd2, 3'd3);
    step(1'b1, 2'b10, 16'h0000, 16'h2222, 3'd1, 3'd1, 3'd1);
    step(1'b0, 2'b00, 16'h0000, 16'h0000, 3'd0, 3'd1, 3'd2);
    // commit immediately after reset, no dead cycle
    step(1'b0, 2'b10, 16'h0000, 16'h3333, 3'd6, 3'd6, 3'd7);
    // twenty back-to-back commits wrap the 4-bit counter copy
    for (int i = 0; i < 20; i++)
      step(1'b0, 2'b10, 16'h0000, 16'($urandom), 3'(1 + (i % 7)), 3'(i % 8), 3'((i + 3) % 8));

    // random traffic with occasional reset; read addresses biased toward treg
    for (int i = 0; i < 1500; i++) begin
      t_r  = 3'($urandom_range(0, 7));
      a1_r = ($urandom_range(0, 3) == 0) ? t_r : 3'($urandom_range(0, 7));
      a2_r = ($urandom_range(0, 3) == 0) ? a1_r : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), t_r, a1_r, a2_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file; sits directly downstream of the MEM/WB pipeline register.
- Consumes the WB control pair, memory read data, ALU result and 3-bit target register from MEM/WB.
- Selects the write-back value, commits it to an 8 x 16-bit register file, and serves two combinational read ports to the decode stage with same-cycle write bypass.
- Also keeps a retired-write counter for debug and performance.

Parameters:
- DATA_W, 16, datapath width; matches MEM/WB ReadData/AluOut.
- ADDR_W, 3, register index width; matches MEM/WB TReg.
- REG_N, 8, number of registers; must equal 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
- CNT_W, 16, width of retired-write counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_in  input  2  WB control from MEM/WB: bit1 = RegWrite, bit0 = MemToReg.
- read_data_in  input  DATA_W  memory load data from MEM/WB.
- alu_out_in  input  DATA_W  ALU result from MEM/WB.
- treg_in  input  ADDR_W  destination register index from MEM/WB.
- rs1_addr  input  ADDR_W  read port 1 index, from decode.
- rs2_addr  input  ADDR_W  read port 2 index, from decode.
- rs1_data  output  DATA_W  read port 1 data, combinational.
- rs2_data  output  DATA_W  read port 2 data, combinational.
- wb_data  output  DATA_W  selected write-back value, combinational; for forwarding to EX.
- wb_we  output  1  effective write enable this cycle, combinational.
- retired_cnt  output  CNT_W  registered count of committed writes.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst is sampled only at the rising edge of clk.
- Write-back select: wb_data = alu_out_in when wb_in[0] = 0; wb_data = read_data_in when wb_in[0] = 1.
- Write enable: wb_we = wb_in[1] AND NOT rst AND NOT (ZERO_REG = 1 AND treg_in = 0).
- Commit: at posedge clk with wb_we = 1, reg[treg_in] <= wb_data. Commit latency is one edge.
- Reads are asynchronous:
  - rsN_data = 0 if ZERO_REG = 1 and rsN_addr = 0.
  - Otherwise rsN_data = wb_data if wb_we = 1 and rsN_addr = treg_in (write-first bypass).
  - Otherwise rsN_data = reg[rsN_addr].
- Both ports may address the same register; both return the identical value, bypass included.
- Counter: at posedge with wb_we = 1, retired_cnt <= retired_cnt + 1. Wraps modulo 2**CNT_W with no flag.
- Reset, at posedge with rst = 1:
  - All REG_N registers <= 0 and retired_cnt <= 0.
  - Any concurrent write is discarded; rst has priority over wb_in[1].
- Values while rst is asserted: rs1_data, rs2_data = 0 for all addresses by the first edge after rst rises. wb_data still follows the mux. wb_we = 0.
- After reset deasserts, the first edge with wb_we = 1 commits normally with no dead cycle.
- Reset mid-operation: a write present on the same edge as rst is lost. The pipeline upstream is flushed by the same rst.
- wb_in[1] = 0: no state change regardless of the other inputs. wb_in[0] only affects the wb_data value.
- X-safety: with wb_in[1] = 0 and unknown data inputs, registers and counter stay known.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W and ADDR_W constants.
  - WB field indices WB_REGWRITE = 1, WB_MEMTOREG = 0.
  - Type for the 2-bit WB control bundle.
  - These are shared with the ID/EX, EX/MEM and MEM/WB registers and the control unit.
- One sub-module, regfile_core:
  - The storage array with reset, one write port, two bypassed read ports and ZERO_REG handling.
  - wb_regfile adds the write-back mux, write-enable qualification and retired counter.

Test Plan:
- Reset: hold rst for 2 cycles with wb_in = 2'b10, treg_in = 3, alu_out_in = 16'h1234 -> no write occurs; rs1_addr = 3 reads 0; retired_cnt = 0.
- ALU write: wb_in = 2'b10, treg_in = 5, alu_out_in = 16'hBEEF, rs1_addr = 5 on the same cycle -> rs1_data = 16'hBEEF via bypass; after the edge reg5 = 16'hBEEF; retired_cnt = 1.
- Load write: wb_in = 2'b11, read_data_in = 16'h00A5, alu_out_in = 16'hFFFF, treg_in = 2 -> wb_data = 16'h00A5; after the edge rs2_addr = 2 reads 16'h00A5.
- Zero register: wb_in = 2'b10, treg_in = 0, alu_out_in = 16'h7777 -> wb_we = 0; rs1_addr = 0 reads 0; retired_cnt unchanged.
- Write disabled: wb_in = 2'b01, treg_in = 4, read_data_in = 16'h5555 -> reg4 keeps its prior value; wb_data = 16'h5555; rs1_addr = 4 shows the old value.
- Counter wrap and reset priority:
  - Preload retired_cnt = 16'hFFFF; commit one write -> retired_cnt = 0.
  - Then assert rst together with wb_in = 2'b10, treg_in = 1 -> reg1 = 0 after the edge.
